// File: rtl/alarm_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_multi_if
// Brief    : Time/alarm-setting inputs and LED/status outputs of alarm_multi.
// Revision : 1.0
// ============================================================================
interface alarm_multi_if #(
  parameter int NUM_ALARMS = 4,
  parameter int ID_W       = 2,
  parameter int LED_W      = 4
);
  logic [7:0]              sec_time;
  logic [7:0]              min_time;
  logic [7:0]              hour_time;
  logic [8*NUM_ALARMS-1:0] alarm_sec;
  logic [8*NUM_ALARMS-1:0] alarm_min;
  logic [8*NUM_ALARMS-1:0] alarm_hour;
  logic [NUM_ALARMS-1:0]   alarm_en;
  logic                    blink_mode;
  logic                    stop_key;
  logic                    snooze_key;
  logic [LED_W-1:0]        led;
  logic                    alarm_active;
  logic [ID_W-1:0]         alarm_id;

  modport master (
    output sec_time, min_time, hour_time,
    output alarm_sec, alarm_min, alarm_hour, alarm_en,
    output blink_mode, stop_key, snooze_key,
    input  led, alarm_active, alarm_id
  );

  modport slave (
    input  sec_time, min_time, hour_time,
    input  alarm_sec, alarm_min, alarm_hour, alarm_en,
    input  blink_mode, stop_key, snooze_key,
    output led, alarm_active, alarm_id
  );
endinterface
`default_nettype wire

// File: rtl/alarm_multi.sv
`default_nettype none
// ============================================================================
// Module   : alarm_multi
// Brief    : Multi-channel alarm controller with snooze, stop and blink LEDs.
// Revision : 1.0
// ============================================================================
module alarm_multi #(
  parameter int NUM_ALARMS  = 4,
  parameter int ID_W        = 2,
  parameter int LED_W       = 4,
  parameter int KEEP_TIME   = 50,
  parameter int SNOOZE_TIME = 100,
  parameter int BLINK_TIME  = 10,
  parameter int MAX_SNOOZE  = 3,
  parameter int CNT_W       = 30
) (
  input wire logic     clk,
  input wire logic     reset,
  alarm_multi_if.slave bus
);

  localparam int SNZ_W = (MAX_SNOOZE < 2) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam int BLK_W = (BLINK_TIME < 2) ? 1 : $clog2(BLINK_TIME);

  localparam logic [CNT_W-1:0] c_KEEP_LAST   = CNT_W'(KEEP_TIME - 1);
  localparam logic [CNT_W-1:0] c_SNOOZE_LAST = CNT_W'(SNOOZE_TIME - 1);
  localparam logic [BLK_W-1:0] c_BLINK_LAST  = BLK_W'(BLINK_TIME - 1);
  localparam logic [SNZ_W-1:0] c_MAX_SNZ     = SNZ_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [SNZ_W-1:0]      r_snz_cnt, w_snz_nxt;
  logic [BLK_W-1:0]      r_blink_cnt, w_blink_cnt_nxt;
  logic                  r_blink_ph, w_blink_ph_nxt;
  logic [ID_W-1:0]       r_alarm_id, w_id_nxt;
  logic [NUM_ALARMS-1:0] w_match, r_match_q, w_trig;
  logic [ID_W-1:0]       w_trig_id;
  logic                  w_trig_any;
  logic                  w_cur_en;

  generate
    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_match
      assign w_match[k] = (bus.alarm_sec[8*k +: 8]  == bus.sec_time) &&
                          (bus.alarm_min[8*k +: 8]  == bus.min_time) &&
                          (bus.alarm_hour[8*k +: 8] == bus.hour_time);
    end
  endgenerate

  // Only the rising edge of a match fires; match_q powers up all-ones so a
  // time already matching at reset release is ignored.
  assign w_trig = w_match & ~r_match_q & bus.alarm_en;

  always_comb begin
    w_trig_any = |w_trig;
    w_trig_id  = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (w_trig[k]) w_trig_id = ID_W'(k);
    end
    w_cur_en = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (r_alarm_id == ID_W'(k)) w_cur_en = bus.alarm_en[k];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_snz_nxt       = r_snz_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_ph_nxt  = r_blink_ph;
    w_id_nxt        = r_alarm_id;
    case (r_state)
      ST_IDLE: begin
        if (w_trig_any) begin
          w_state_nxt     = ST_RING;
          w_id_nxt        = w_trig_id;
          w_cnt_nxt       = '0;
          w_snz_nxt       = '0;
          w_blink_ph_nxt  = 1'b1;
          w_blink_cnt_nxt = '0;
        end
      end
      ST_RING: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_blink_cnt == c_BLINK_LAST) begin
          w_blink_cnt_nxt = '0;
          w_blink_ph_nxt  = ~r_blink_ph;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + BLK_W'(1);
        end
        if (!w_cur_en || bus.stop_key) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.snooze_key) begin
          // Snooze past the limit behaves as stop.
          if (r_snz_cnt < c_MAX_SNZ) begin
            w_state_nxt = ST_SNOOZE;
            w_cnt_nxt   = '0;
            w_snz_nxt   = r_snz_cnt + SNZ_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_cnt == c_KEEP_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!w_cur_en || bus.stop_key) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_SNOOZE_LAST) begin
          w_state_nxt     = ST_RING;
          w_cnt_nxt       = '0;
          w_blink_ph_nxt  = 1'b1;
          w_blink_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_snz_cnt   <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_alarm_id  <= '0;
      r_match_q   <= '1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_snz_cnt   <= w_snz_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_ph  <= w_blink_ph_nxt;
      r_alarm_id  <= w_id_nxt;
      r_match_q   <= w_match;
    end
  end

  assign bus.alarm_active = (r_state != ST_IDLE);
  assign bus.alarm_id     = r_alarm_id;
  assign bus.led          = ((r_state == ST_RING) && (!bus.blink_mode || r_blink_ph))
                            ? {LED_W{1'b1}} : {LED_W{1'b0}};

endmodule
`default_nettype wire
